// File: rtl/sva_chk_pkg.sv
// Shared types and helpers for the sequence-implication checker.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package sva_chk_pkg;

    localparam int MAX_DELAY = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } chk_state_e;

    // Counters up to 64 bits share this; callers zero-extend in and truncate out.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        return (val >= max_val) ? val : val + 64'd1;
    endfunction

endpackage

// File: rtl/sva_delay_line.sv
// DEPTH-deep single-bit shift register with synchronous flush.
// Latency: DEPTH shifts from din to q[DEPTH-1].
// Backpressure: none; shifts only when shift=1, flush wins over shift.
module sva_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             flush,
    input  logic             din,
    output logic [DEPTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q <= '0;
        end else if (shift) begin
            q[0] <= din;
            for (int k = 1; k < DEPTH; k++) begin
                q[k] <= q[k-1];
            end
        end
    end

endmodule

// File: rtl/sva_seq_impl_checker.sv
// Run-time checker for (a ##DELAY b) |-> c (or |=> c) with stats and first-fail stamp.
// Latency: result registered after the edge sampling the deciding c (DELAY or DELAY+1 edges after a).
// Backpressure: none; one result per edge, attempts aborted whenever checking is inactive.
module sva_seq_impl_checker
    import sva_chk_pkg::*;
#(
    parameter int DELAY        = 1,
    parameter int NONOVERLAP   = 0,
    parameter int STOP_ON_FAIL = 0,
    parameter int CNT_W        = 16,
    parameter int CYC_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic [CYC_W-1:0] cyc,
    output logic             pass,
    output logic             fail,
    output logic             halted,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             first_fail_vld,
    output logic [CYC_W-1:0] first_fail_cyc
);

    if (DELAY < 1 || DELAY > MAX_DELAY) begin : g_bad_delay
        $error("sva_seq_impl_checker: DELAY must be within 1..15");
    end
    if (CNT_W < 1 || CNT_W > 64) begin : g_bad_cnt_w
        $error("sva_seq_impl_checker: CNT_W must be within 1..64");
    end

    chk_state_e       state;
    chk_state_e       state_nxt;
    logic [DELAY-1:0] pend;
    logic             oblig;
    logic             active;
    logic             match;
    logic             res_vld;
    logic             res_pass;
    logic             res_fail;

    // en low at an edge aborts everything sampled at that edge, even while still in RUN.
    assign active   = (state == RUN) && en;
    assign match    = active && pend[DELAY-1] && b;
    assign res_vld  = active && ((NONOVERLAP != 0) ? oblig : match);
    assign res_pass = res_vld && c;
    assign res_fail = res_vld && !c;

    sva_delay_line #(
        .DEPTH (DELAY)
    ) u_pend (
        .clk   (clk),
        .rst   (rst),
        .shift (active),
        .flush (!active),
        .din   (a),
        .q     (pend)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en) state_nxt = RUN;
            end
            RUN: begin
                if (res_fail && (STOP_ON_FAIL != 0) && !clr) state_nxt = HALT;
                else if (!en)                                state_nxt = IDLE;
            end
            HALT: begin
                if (clr) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            oblig <= 1'b0;
        end else begin
            state <= state_nxt;
            oblig <= match;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass           <= 1'b0;
            fail           <= 1'b0;
            halted         <= 1'b0;
            match_cnt      <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_vld <= 1'b0;
            first_fail_cyc <= '0;
        end else begin
            pass   <= res_pass;
            fail   <= res_fail;
            halted <= (state_nxt == HALT);
            if (clr) begin
                match_cnt      <= '0;
                pass_cnt       <= '0;
                fail_cnt       <= '0;
                first_fail_vld <= 1'b0;
                first_fail_cyc <= '0;
            end else begin
                if (match)    match_cnt <= CNT_W'(sat_inc(64'(match_cnt), CNT_W));
                if (res_pass) pass_cnt  <= CNT_W'(sat_inc(64'(pass_cnt), CNT_W));
                if (res_fail) fail_cnt  <= CNT_W'(sat_inc(64'(fail_cnt), CNT_W));
                if (res_fail && !first_fail_vld) begin
                    first_fail_vld <= 1'b1;
                    first_fail_cyc <= cyc;
                end
            end
        end
    end

endmodule

// File: doc/sva_seq_impl_checker.md
# sva_seq_impl_checker

Synthesizable run-time checker for the sequence-antecedent implication (a ##DELAY b) |-> c, or |=> c when NONOVERLAP=1. It tracks every overlapping attempt in flight, issues per-attempt pass/fail pulses, and keeps saturating statistics plus a first-failure cycle stamp. It sits beside the design under test in regression benches as a hardware counterpart to the native assertion, so results can be cross-checked cycle by cycle.

## Interface
- DELAY, 1: cycles between antecedent `a` and `b`; legal range 1..15.
- NONOVERLAP, 0: 0 checks `c` in the `b` cycle (|->); 1 checks `c` one cycle later (|=>).
- STOP_ON_FAIL, 0: 1 halts checking after the first failure.
- CNT_W, 16: width of the statistics counters.
- CYC_W, 32: width of the cycle stamp.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  checking enable.
- clr  in  1  synchronous clear of statistics, first-fail capture and HALT.
- a, b, c  in  1 each  sequence signals, sampled at posedge.
- cyc  in  CYC_W  external cycle stamp, sampled at posedge.
- pass  out  1  one-cycle pulse per successful attempt.
- fail  out  1  one-cycle pulse per failed attempt.
- halted  out  1  high while the FSM is in HALT.
- match_cnt  out  CNT_W  antecedent matches.
- pass_cnt  out  CNT_W  passes.
- fail_cnt  out  CNT_W  failures.
- first_fail_vld  out  1  a failure has been captured.
- first_fail_cyc  out  CYC_W  `cyc` value at the edge where the first failing `c` was sampled.

## Operation
- FSM states:
  - IDLE: `en`=0.
  - RUN: `en`=1.
  - HALT: entered only when STOP_ON_FAIL=1 and a fail occurs; left only by `rst` or `clr`, which both go to IDLE.
- Transitions: IDLE→RUN when `en`=1. RUN→IDLE when `en`=0.
- Pending line `pend[1..DELAY]`: in RUN, `pend[1]<=a`, `pend[k]<=pend[k-1]`. In IDLE or HALT the line is cleared. Attempts are aborted with no pass/fail, counted nowhere.
- Antecedent match at edge t: RUN && `pend[DELAY]` && `b`. Increments `match_cnt`.
- NONOVERLAP=0: at a match edge, `c`=1 → pass, `c`=0 → fail.
- NONOVERLAP=1: a match sets obligation flop `oblig`. At the next edge, if `oblig` is set, sample `c` for pass/fail.
  - An obligation whose check edge falls in IDLE is dropped.
  - Matches on consecutive edges chain naturally, one result per edge.
- Counters saturate at all-ones and never wrap. `clr` zeroes all three counters.
- First fail: on the first fail while `first_fail_vld`=0, capture `cyc` and set `first_fail_vld`. Later fails do not overwrite it.
- Same-edge conflicts:
  - `clr` beats a same-edge increment or capture; the event is lost.
  - `rst` beats everything.
  - A fail that triggers HALT is itself counted and pulsed.
- Reset values: all outputs 0, FSM IDLE, `pend` and `oblig` 0.

## Timing
- All outputs are registered. `pass`/`fail` and counter updates become visible right after the edge that sampled the deciding `c`.
  - Overlap: the `b` edge.
  - Nonoverlap: the `b` edge + 1.
- Latency from the `a` sample to the result: DELAY edges (overlap) or DELAY+1 edges (nonoverlap).
- `en` rising at edge t: the first `a` is sampled at t+1 (FSM in RUN).
- `en` falling: the line clears at that edge, and no result is produced at that edge.
- `pass` and `fail` are never high together. At most one result per edge.

## Structure
- Package `sva_chk_pkg` holds:
  - the typedef enum for FSM states {IDLE, RUN, HALT};
  - the function `sat_inc` (saturating increment);
  - the constant MAX_DELAY=15.
- Sub-module `sva_delay_line`: a DELAY-deep shift register with synchronous flush. Instantiated once for `pend`.
- Top level holds the FSM, match/oblig logic, counters and capture. Elaboration-time check: DELAY range.

## Test plan
- DELAY=1, overlap, `c`=1 constantly, `a`=1 at cyc 5, `b`=1 at cyc 6 → one `pass` after edge 6; match_cnt=1, pass_cnt=1, fail_cnt=0.
- Same stimulus with `c`=0 at cyc 6 → one `fail`; first_fail_vld=1, first_fail_cyc=6. Repeat at cyc 10 → fail_cnt=2, first_fail_cyc stays 6.
- Overlapping attempts: `a`=1 at cyc 5–7, `b`=1 at cyc 6–8, `c`=1 → three consecutive pass pulses; match_cnt=3.
- NONOVERLAP=1, DELAY=2: `a` at cyc 4, `b` at 6, `c`=0 at 6 and `c`=1 at 7 → pass after edge 7, no fail.
- Abort and reset:
  - `a` at cyc 5, `en`=0 at cyc 6 with `b`=1 → no pulse, match_cnt=0.
  - `rst` pulsed at cyc 6 with an attempt pending → all outputs 0, no result.
- STOP_ON_FAIL=1, CNT_W=2: five passes → pass_cnt=3 (saturated). Then a fail → halted=1 and later matches are ignored. `clr` → counters 0, halted=0, FSM IDLE.
